// File: rtl/seven_segment_scanner_if.sv
// Display bus for seven_segment_scanner: enable/load/data in, segment pattern, digit select and frame pulse out.
// master drives the data side (board logic or bench); slave is the scanner.
interface seven_segment_scanner_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    en;
   logic                    load;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]   dps;
   logic [7:0]              ssd;
   logic [NUM_DIGITS-1:0]   anode;
   logic                    frame_done;

   modport master (
      output en, load, digits, dps,
      input  ssd, anode, frame_done
   );

   modport slave (
      input  en, load, digits, dps,
      output ssd, anode, frame_done
   );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed multi-digit seven-segment scanner fed from a load-captured shadow register.
// Optional feature macro SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is always shown).
module seven_segment_scanner #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000
) (
   input logic clk,
   input logic rst_n,
   seven_segment_scanner_if.slave bus
);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [4*NUM_DIGITS-1:0] shadow_digits;
   logic [NUM_DIGITS-1:0]   shadow_dps;
   logic [CNT_W-1:0]        prescale;
   logic [IDX_W-1:0]        idx;
   logic                    tick;
   logic                    last_digit;
   logic [NUM_DIGITS-1:0]   blank;
   logic [3:0]              sel_nib;
   logic                    sel_dp;
   logic                    sel_blank;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
      logic [6:0] seg;
      seg = 7'h00;
      case (hex)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         4'hF: seg = 7'h71;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

   // NOTE: the shadow register is a handful of flops, not a RAM, so it is reset and a
   // freshly reset display shows zeros rather than stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_digits <= '0;
         shadow_dps    <= '0;
      end else if (bus.load) begin
         // NOTE: non-blocking so every flop samples pre-edge values, whatever the process order.
         shadow_digits <= bus.digits;
         shadow_dps    <= bus.dps;
      end
   end

   assign tick       = bus.en && (prescale == CNT_W'(REFRESH_DIV - 1));
   assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));

   // Disable has priority over a coincident tick, so scanning always restarts at digit 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescale <= '0;
         idx      <= '0;
      end else if (!bus.en) begin
         prescale <= '0;
         idx      <= '0;
      end else if (tick) begin
         prescale <= '0;
         idx      <= last_digit ? '0 : idx + IDX_W'(1);
      end else begin
         prescale <= prescale + CNT_W'(1);
      end
   end

`ifdef SSD_LEADING_ZERO_BLANK_EN
   // Walk down from the top digit; the first nonzero nibble or lit DP ends the blank run.
   always_comb begin
      logic run;
      run   = 1'b1;
      blank = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         if (shadow_digits[4*i +: 4] != 4'h0 || shadow_dps[i]) run = 1'b0;
         blank[i] = run;
      end
   end
`else
   assign blank = '0;
`endif

   always_comb begin
      // NOTE: defaults first so every path assigns these and no latch is inferred.
      sel_nib   = 4'h0;
      sel_dp    = 1'b0;
      sel_blank = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            sel_nib   = shadow_digits[4*i +: 4];
            sel_dp    = shadow_dps[i];
            sel_blank = blank[i];
         end
      end
   end

   // Anode, SSD and frame_done share one register stage so they always change together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.anode      <= '0;
         bus.ssd        <= '0;
         bus.frame_done <= 1'b0;
      end else if (!bus.en) begin
         bus.anode      <= '0;
         bus.ssd        <= '0;
         bus.frame_done <= 1'b0;
      end else begin
         bus.anode      <= NUM_DIGITS'(1) << idx;
         bus.ssd        <= sel_blank ? 8'h00 : {sel_dp, hex_to_seg(sel_nib)};
         bus.frame_done <= tick && last_digit;
      end
   end
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner (NUM_DIGITS=4, REFRESH_DIV=4).
// Expected per-cycle outputs are queued as stimulus is driven and compared one cycle at a time.
module tb_seven_segment_scanner;
   localparam int ND = 4;
   localparam int RD = 4;
   localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   typedef struct {
      string      tag;
      logic [3:0] anode;
      logic [7:0] ssd;
      logic       fd;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t exp_q[$];
   logic [15:0] sh_digits;
   logic [3:0]  sh_dps;

   always #5 clk = ~clk;

   seven_segment_scanner_if #(.NUM_DIGITS(ND)) bus ();

   seven_segment_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic logic [7:0] exp_ssd(input int d);
      logic [3:0] nib;
      logic       blank;
      nib   = sh_digits[4*d +: 4];
      blank = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
      if (d != 0) begin
         blank = 1'b1;
         for (int i = ND - 1; i >= d; i--)
            if (sh_digits[4*i +: 4] != 4'h0 || sh_dps[i]) blank = 1'b0;
      end
`endif
      return blank ? 8'h00 : {sh_dps[d], SEG[nib]};
   endfunction

   task automatic push_exp(input string tag, input logic [3:0] an, input logic [7:0] sd, input logic fd);
      exp_t e;
      e.tag = tag; e.anode = an; e.ssd = sd; e.fd = fd;
      exp_q.push_back(e);
   endtask

   task automatic push_digit(input string tag, input int d, input int n, input logic fd_last);
      for (int k = 0; k < n; k++)
         push_exp(tag, 4'(1) << d, exp_ssd(d), fd_last && (k == n - 1));
   endtask

   task automatic push_frame(input string tag);
      for (int d = 0; d < ND; d++) push_digit(tag, d, RD, d == ND - 1);
   endtask

   task automatic drain();
      exp_t e;
      while (exp_q.size() > 0) begin
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         check({e.tag, "_anode"}, 32'(bus.anode), 32'(e.anode));
         check({e.tag, "_ssd"}, 32'(bus.ssd), 32'(e.ssd));
         check({e.tag, "_fd"}, 32'(bus.frame_done), 32'(e.fd));
      end
   endtask

   // One disabled cycle that captures new data, then scanning resumes at digit 0.
   task automatic load_restart(input logic [15:0] dg, input logic [3:0] dp);
      bus.en     = 1'b0;
      bus.load   = 1'b1;
      bus.digits = dg;
      bus.dps    = dp;
      sh_digits  = dg;
      sh_dps     = dp;
      push_exp("restart", 4'h0, 8'h00, 1'b0);
      drain();
      bus.load = 1'b0;
      bus.en   = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      bus.en     = 1'b1;
      bus.load   = 1'b1;
      bus.digits = 16'h0000;
      bus.dps    = 4'h0;
      sh_digits  = 16'h0000;
      sh_dps     = 4'h0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_ssd", 32'(bus.ssd), 32'h0);
      check("reset_anode", 32'(bus.anode), 32'h0);
      check("reset_fd", 32'(bus.frame_done), 32'h0);

      rst_n = 1'b1;
      push_digit("release", 0, 1, 1'b0);
      drain();

      // Two full frames: dwell, order, DP and one frame_done per 16 cycles.
      load_restart(16'h1A2F, 4'b0100);
      push_frame("scan1");
      push_frame("scan2");
      drain();

      // Drop enable in the middle of digit 2, then re-raise.
      push_digit("gate_pre", 0, RD, 1'b0);
      push_digit("gate_pre", 1, RD, 1'b0);
      push_digit("gate_pre", 2, 2, 1'b0);
      drain();
      bus.en = 1'b0;
      push_exp("gate_off", 4'h0, 8'h00, 1'b0);
      push_exp("gate_off", 4'h0, 8'h00, 1'b0);
      drain();
      bus.en = 1'b1;
      push_digit("gate_on", 0, RD, 1'b0);
      push_digit("gate_on", 1, 1, 1'b0);
      drain();

      // Load coinciding with the tick edge that advances to digit 1.
      load_restart(16'h1111, 4'h0);
      push_digit("tick_ld", 0, RD - 1, 1'b0);
      drain();
      bus.load   = 1'b1;
      bus.digits = 16'h2222;
      push_digit("tick_ld", 0, 1, 1'b0);
      sh_digits = 16'h2222;
      drain();
      bus.load = 1'b0;
      push_digit("tick_new", 1, RD, 1'b0);
      push_digit("tick_new", 2, RD, 1'b0);
      push_digit("tick_new", 3, 2, 1'b0);
      drain();

      // Asynchronous reset between edges during digit 3.
      #3;
      rst_n = 1'b0;
      #1;
      check("async_ssd", 32'(bus.ssd), 32'h0);
      check("async_anode", 32'(bus.anode), 32'h0);
      check("async_fd", 32'(bus.frame_done), 32'h0);
      sh_digits = 16'h0000;
      sh_dps    = 4'h0;
      #2;
      rst_n = 1'b1;
      push_digit("post_rst", 0, RD, 1'b0);
      push_digit("post_rst", 1, 1, 1'b0);
      drain();

      // Leading-zero behaviour (blanked only when the feature macro is defined).
      load_restart(16'h0050, 4'h0);
      push_frame("lz0050");
      drain();
      load_restart(16'h0000, 4'h0);
      push_frame("lz0000");
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
